// File: rtl/data_memory_ctrl_if.sv
// Bus between the MEM-stage pipeline logic and the data memory controller.
// The pipeline side (master) issues requests; the memory side (slave)
// returns the extended load data, the stall/advance flag and the error flag.
interface data_memory_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemError;

  modport master (
    output MemRead, MemWrite, MemSize, MemUnsigned, Address, WriteData,
    input  ReadData, MemReady, MemError
  );

  modport slave (
    input  MemRead, MemWrite, MemSize, MemUnsigned, Address, WriteData,
    output ReadData, MemReady, MemError
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores with sign or zero
// extension, LATENCY wait cycles per access and a MemReady stall flag.
// Misaligned, out-of-range, size-11 and read+write requests complete
// without touching the array and raise MemError in their DONE cycle.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic               clk,
  input logic               reset,
  data_memory_ctrl_if.slave mem_bus
);
  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Request captured when it is accepted in IDLE
  logic        rd_q, wr_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  // Request as seen by the current cycle: live inputs in IDLE, latched copy
  // afterwards, so a zero-latency access completes on its accepting edge.
  logic        req, rd_e, wr_e, uns_e;
  logic [1:0]  size_e;
  logic [31:0] addr_e, wdata_e;
  logic        enter_done, out_of_range, illegal, mem_we;
  logic [3:0]  lane_en;
  logic [31:0] wlane, word_rd;
  logic [AW-1:0] widx;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  a,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Select the request driving this cycle and classify it
  always_comb begin
    req          = mem_bus.MemRead | mem_bus.MemWrite;
    rd_e         = (state_q == S_IDLE) ? mem_bus.MemRead     : rd_q;
    wr_e         = (state_q == S_IDLE) ? mem_bus.MemWrite    : wr_q;
    uns_e        = (state_q == S_IDLE) ? mem_bus.MemUnsigned : uns_q;
    size_e       = (state_q == S_IDLE) ? mem_bus.MemSize     : size_q;
    addr_e       = (state_q == S_IDLE) ? mem_bus.Address     : addr_q;
    wdata_e      = (state_q == S_IDLE) ? mem_bus.WriteData   : wdata_q;
    out_of_range = ({2'b00, addr_e[31:2]} >= 32'(DEPTH_WORDS));
    illegal      = (rd_e & wr_e) | (size_e == 2'b11)
                 | ((size_e == 2'b01) & addr_e[0])
                 | ((size_e == 2'b10) & (addr_e[1:0] != 2'b00))
                 | out_of_range;
    widx         = addr_e[AW+1:2];
    case (size_e)
      2'b00:   begin lane_en = 4'b0001 << addr_e[1:0];           wlane = {4{wdata_e[7:0]}};  end
      2'b01:   begin lane_en = addr_e[1] ? 4'b1100 : 4'b0011;   wlane = {2{wdata_e[15:0]}}; end
      2'b10:   begin lane_en = 4'b1111;                         wlane = wdata_e;            end
      default: begin lane_en = 4'b0000;                         wlane = wdata_e;            end
    endcase
  end

  // Next state, wait counter and the completion edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result and error registers; the write is suppressed while reset is high
  // so an access cut short on its completion edge leaves the array intact.
  always_comb begin
    word_rd = mem[widx];
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = enter_done & wr_e & ~illegal & ~reset;
    if (enter_done) begin
      err_d   = illegal;
      rdata_d = (illegal | wr_e) ? 32'h0 : load_extract(word_rd, size_e, addr_e[1:0], uns_e);
    end
  end

  // Control and output state, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the request fields when IDLE accepts a request
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      rd_q    <= mem_bus.MemRead;
      wr_q    <= mem_bus.MemWrite;
      uns_q   <= mem_bus.MemUnsigned;
      size_q  <= mem_bus.MemSize;
      addr_q  <= mem_bus.Address;
      wdata_q <= mem_bus.WriteData;
    end
  end

  // Byte-lane write into the storage array
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign mem_bus.ReadData = rdata_q;
  assign mem_bus.MemError = err_q;
  assign mem_bus.MemReady = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);

endmodule
